// File: rtl/jam_pkg.sv
// Shared widths, reset values and FSM encoding for the jam cost arbiter slice.
package jam_pkg;

  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 3;

  localparam logic [SUM_W-1:0] COST_INIT = 10'd1023;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_MERGE   = 2'd1,
    ST_DONE    = 2'd2
  } jam_state_e;

  // Match counts stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Engine-side lookup bus: per-engine requests in, one-hot grant and response out.
// Handshake: a lookup transfers in the cycle where req_valid[i] and req_ready[i] are
// both 1; the engine holds req_valid/req_w/req_j until then; rsp_valid[i] follows one cycle later.
interface jam_cost_arbiter_if #(parameter int NUM_REQ = 2) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [3*NUM_REQ-1:0] req_w;
  logic [3*NUM_REQ-1:0] req_j;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [6:0]           rsp_cost;

  modport master (
    output req_valid, req_w, req_j,
    input  req_ready, rsp_valid, rsp_cost
  );

  modport slave (
    input  req_valid, req_w, req_j,
    output req_ready, rsp_valid, rsp_cost
  );
endinterface

// File: rtl/jam_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module jam_rr_arbiter
  import jam_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   nxt_ptr
);

  logic found;

  // Scan offsets from ptr; the first hit wins and later hits are masked by found.
  always_comb begin
    grant   = '0;
    nxt_ptr = ptr;
    found   = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (((int'(ptr) + off) % NUM_REQ) == i)) begin
          grant[i] = 1'b1;
          nxt_ptr  = IDX_W'((i + 1) % NUM_REQ);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Shares one cost-table port among NUM_REQ search engines and merges their results.
// Optional JAM_ARB_STATS_EN adds per-engine 16-bit grant counters (grant_cnt).
module jam_cost_arbiter
  import jam_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  jam_cost_arbiter_if.slave        bus,
  output logic [2:0]               W,
  output logic [2:0]               J,
  input  logic [COST_W-1:0]        Cost,
  input  logic [NUM_REQ-1:0]       eng_done,
  input  logic [SUM_W*NUM_REQ-1:0] eng_min,
  input  logic [CNT_W*NUM_REQ-1:0] eng_cnt,
  output logic [SUM_W-1:0]         MinCost,
  output logic [CNT_W-1:0]         MatchCount,
  output logic                     Valid,
  output jam_state_e               fsm_state
`ifdef JAM_ARB_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]    grant_cnt
`endif
);

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   nxt_ptr;
  logic [NUM_REQ-1:0] grant;

  jam_state_e state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [NUM_REQ-1:0] done_seen;
  logic [SUM_W-1:0]   cap_min [NUM_REQ];
  logic [CNT_W-1:0]   cap_cnt [NUM_REQ];
  logic [SUM_W-1:0]   sel_min;
  logic [CNT_W-1:0]   sel_cnt;

  jam_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .nxt_ptr (nxt_ptr)
  );

  assign bus.req_ready = grant;

  // Table address follows the granted engine; idle cycles present address 0.
  always_comb begin
    W = '0;
    J = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        W = bus.req_w[3*i +: 3];
        J = bus.req_j[3*i +: 3];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr        <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_cost  <= '0;
    end else begin
      bus.rsp_valid <= grant;
      bus.rsp_cost  <= Cost;
      if (|grant) rr_ptr <= nxt_ptr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (&done_seen) state_d = ST_MERGE;
      ST_MERGE:   if (idx_q == IDX_W'(NUM_REQ - 1)) state_d = ST_DONE;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_COLLECT;
    endcase
  end

  assign Valid     = (state_q == ST_DONE);
  assign fsm_state = state_q;

  always_comb begin
    sel_min = COST_INIT;
    sel_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_min = cap_min[i];
        sel_cnt = cap_cnt[i];
      end
    end
  end

  // Captures are refreshed while an engine's done level is high; only COLLECT listens.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q      <= '0;
      done_seen  <= '0;
      MinCost    <= COST_INIT;
      MatchCount <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cap_min[i] <= COST_INIT;
        cap_cnt[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_COLLECT: begin
          idx_q <= '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (eng_done[i]) begin
              done_seen[i] <= 1'b1;
              cap_min[i]   <= eng_min[SUM_W*i +: SUM_W];
              cap_cnt[i]   <= eng_cnt[CNT_W*i +: CNT_W];
            end
          end
        end
        ST_MERGE: begin
          idx_q <= idx_q + 1'b1;
          if (sel_min < MinCost) begin
            MinCost    <= sel_min;
            MatchCount <= sel_cnt;
          end else if (sel_min == MinCost) begin
            MatchCount <= sat_add(MatchCount, sel_cnt);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JAM_ARB_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jam_cost_arbiter.sv
// Directed bench for jam_cost_arbiter: arbitration, response latency and result merge.
module tb_jam_cost_arbiter;
  import jam_pkg::*;

  localparam int N = 2;

  logic             CLK;
  logic             RST;
  logic [2:0]       W, J;
  logic [6:0]       Cost;
  logic [N-1:0]     eng_done;
  logic [10*N-1:0]  eng_min;
  logic [4*N-1:0]   eng_cnt;
  logic [9:0]       MinCost;
  logic [3:0]       MatchCount;
  logic             Valid;
  jam_state_e       fsm_state;
`ifdef JAM_ARB_STATS_EN
  logic [16*N-1:0]  grant_cnt;
`endif

  logic [6:0] rom [64];
  logic [6:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  jam_cost_arbiter_if #(.NUM_REQ(N)) bus ();

  jam_cost_arbiter #(.NUM_REQ(N)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus.slave),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .eng_done   (eng_done),
    .eng_min    (eng_min),
    .eng_cnt    (eng_cnt),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .Valid      (Valid),
    .fsm_state  (fsm_state)
`ifdef JAM_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  assign Cost = rom[{W, J}];

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply_reset();
    RST           = 1'b1;
    bus.req_valid = '0;
    bus.req_w     = '0;
    bus.req_j     = '0;
    eng_done      = '0;
    eng_min       = '0;
    eng_cnt       = '0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_engines(input logic [1:0] done, input int m0, input int c0,
                             input int m1, input int c1);
    eng_min  = {10'(m1), 10'(m0)};
    eng_cnt  = {4'(c1), 4'(c0)};
    eng_done = done;
  endtask

  // Edges after the final done edge until Valid, bounded.
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    while (!Valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(n), 32'(exp_lat));
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [2:0] wv [2];
    logic [2:0] jv [2];
    logic [6:0] exp_cost;
    int g;

    for (int i = 0; i < 64; i++) rom[i] = 7'((i * 11 + 5) % 128);
    rom[2*8+5] = 7'd17;

    // reset state
    apply_reset();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_cost",  32'(bus.rsp_cost),  32'd0);
    chk("rst_mincost",   32'(MinCost),       32'd1023);
    chk("rst_matchcnt",  32'(MatchCount),    32'd0);
    chk("rst_valid",     32'(Valid),         32'd0);
    chk("rst_state",     32'(fsm_state),     32'(ST_COLLECT));
    chk("rst_ready",     32'(bus.req_ready), 32'd0);

    // single requester, then pointer hold across an idle cycle
    bus.req_valid = 2'b01;
    bus.req_w     = {3'd0, 3'd2};
    bus.req_j     = {3'd0, 3'd5};
    @(negedge CLK);
    chk("t1_ready", 32'(bus.req_ready), 32'd1);
    chk("t1_w",     32'(W),             32'd2);
    chk("t1_j",     32'(J),             32'd5);
    step();
    bus.req_valid = 2'b00;
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t1_rsp_cost",  32'(bus.rsp_cost),  32'd17);
    @(negedge CLK);
    chk("t1_idle_ready", 32'(bus.req_ready), 32'd0);
    chk("t1_idle_w",     32'(W),             32'd0);
    step();
    chk("t1_idle_rsp", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = 2'b11;
    @(negedge CLK);
    chk("t1_ptr_hold", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 2'b00;

    // both engines request continuously from reset
    apply_reset();
    wv[0] = 3'd1; jv[0] = 3'd3; wv[1] = 3'd6; jv[1] = 3'd0;
    bus.req_valid = 2'b11;
    bus.req_w     = {wv[1], wv[0]};
    bus.req_j     = {jv[1], jv[0]};
    exp_g = 2'b01;
    for (int n = 0; n < 8; n++) begin
      g = exp_g[1] ? 1 : 0;
      @(negedge CLK);
      chk("t2_ready", 32'(bus.req_ready), 32'(exp_g));
      chk("t2_w",     32'(W),             32'(wv[g]));
      exp_q.push_back(rom[{wv[g], jv[g]}]);
      step();
      chk("t2_rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
      if (exp_q.size() > 0) begin
        exp_cost = exp_q.pop_front();
        chk("t2_rsp_cost", 32'(bus.rsp_cost), 32'(exp_cost));
      end
      wv[g] = 3'((n * 3 + 2) % 8);
      jv[g] = 3'((n * 5 + 1) % 8);
      bus.req_w = {wv[1], wv[0]};
      bus.req_j = {jv[1], jv[0]};
      exp_g = {exp_g[0], exp_g[1]};
    end
    bus.req_valid = 2'b00;
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // simultaneous dones, equal mins
    apply_reset();
    set_engines(2'b11, 300, 2, 300, 3);
    step();
    wait_valid("t3_latency", 3);
    chk("t3_mincost",  32'(MinCost),    32'd300);
    chk("t3_matchcnt", 32'(MatchCount), 32'd5);
    chk("t3_state",    32'(fsm_state),  32'(ST_DONE));

    // staggered dones, lower min from engine 1
    apply_reset();
    set_engines(2'b10, 0, 0, 250, 1);
    repeat (4) step();
    chk("t4_not_valid", 32'(Valid), 32'd0);
    chk("t4_state",     32'(fsm_state), 32'(ST_COLLECT));
    set_engines(2'b11, 260, 4, 250, 1);
    step();
    wait_valid("t4_latency", 3);
    chk("t4_mincost",  32'(MinCost),    32'd250);
    chk("t4_matchcnt", 32'(MatchCount), 32'd1);

    // saturating count, then arbitration and done-ignore while in DONE
    apply_reset();
    set_engines(2'b11, 400, 9, 400, 9);
    step();
    wait_valid("t5_latency", 3);
    chk("t5_mincost",  32'(MinCost),    32'd400);
    chk("t5_matchcnt", 32'(MatchCount), 32'd15);
    bus.req_valid = 2'b10;
    bus.req_w     = {3'd2, 3'd0};
    bus.req_j     = {3'd5, 3'd0};
    set_engines(2'b00, 5, 1, 5, 1);
    @(negedge CLK);
    chk("t5_done_ready", 32'(bus.req_ready), 32'd2);
    step();
    bus.req_valid = 2'b00;
    chk("t5_done_rsp_valid", 32'(bus.rsp_valid), 32'd2);
    chk("t5_done_rsp_cost",  32'(bus.rsp_cost),  32'd17);
    set_engines(2'b11, 5, 1, 5, 1);
    repeat (3) step();
    chk("t5_valid_held", 32'(Valid),   32'd1);
    chk("t5_min_held",   32'(MinCost), 32'd400);

    // reset during merge, then a fresh run
    apply_reset();
    set_engines(2'b11, 200, 3, 150, 2);
    repeat (3) step();
    chk("t6_in_merge", 32'(fsm_state), 32'(ST_MERGE));
    chk("t6_partial",  32'(MinCost),   32'd200);
    #2 RST = 1'b1;
    #1;
    chk("t6_rst_min",   32'(MinCost),    32'd1023);
    chk("t6_rst_cnt",   32'(MatchCount), 32'd0);
    chk("t6_rst_valid", 32'(Valid),      32'd0);
    chk("t6_rst_state", 32'(fsm_state),  32'(ST_COLLECT));
    set_engines(2'b00, 0, 0, 0, 0);
    step();
    RST = 1'b0;
    step();
    chk("t6_idle_valid", 32'(Valid), 32'd0);
    set_engines(2'b11, 500, 2, 100, 7);
    step();
    wait_valid("t6_latency", 3);
    chk("t6_mincost",  32'(MinCost),    32'd100);
    chk("t6_matchcnt", 32'(MatchCount), 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
